// File: rtl/riscv_pkg.sv
// Shared pipeline types: writeback source select, load funct3 encodings and l3 FSM states.
package riscv_pkg;

   typedef enum logic [1:0] {
      WbAlu = 2'd0,
      WbMem = 2'd1,
      WbPc4 = 2'd2
   } wb_sel_e;

   localparam logic [2:0] Funct3Lb  = 3'b000;
   localparam logic [2:0] Funct3Lh  = 3'b001;
   localparam logic [2:0] Funct3Lw  = 3'b010;
   localparam logic [2:0] Funct3Lbu = 3'b100;
   localparam logic [2:0] Funct3Lhu = 3'b101;

   typedef enum logic {
      StIdle,
      StWait
   } state_e;

endpackage

// File: rtl/load_ext.sv
// Load data alignment and extension: picks the addressed byte/half from a word-aligned
// response and sign- or zero-extends it according to the load funct3.
module load_ext
   import riscv_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[8*off +: 8];
      half_sel = off[1] ? word[31:16] : word[15:0];
      case (funct3)
         Funct3Lb:  value = {{24{byte_sel[7]}}, byte_sel};
         Funct3Lh:  value = {{16{half_sel[15]}}, half_sel};
         Funct3Lbu: value = {24'd0, byte_sel};
         Funct3Lhu: value = {16'd0, half_sel};
         // LW and every reserved encoding return the full word
         default:   value = word;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// l3 register/writeback stage: captures the retiring l2 instruction, selects its result
// and holds l2 while a variable-latency load response is outstanding.
module wb_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_l2,
   input  logic [4:0]      rd_l2,
   input  logic [1:0]      wb_sel_l2,
   input  logic [2:0]      funct3_l2,
   input  logic [XLEN-1:0] alu_res_l2,
   input  logic [XLEN-1:0] pc4_l2,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_rvalid,
   output logic            stall_l2,
   output logic            we_l3,
   output logic [4:0]      rd_l3,
   output logic [XLEN-1:0] wval_l3
);

   state_e          state_q, state_d;
   logic [4:0]      ld_rd_q, ld_rd_d;
   logic [2:0]      ld_f3_q, ld_f3_d;
   logic [1:0]      ld_off_q, ld_off_d;
   logic            we_q, we_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] wval_q, wval_d;
   logic [XLEN-1:0] ld_value;

   load_ext u_load_ext (
      .word   (dmem_rdata),
      .off    (ld_off_q),
      .funct3 (ld_f3_q),
      .value  (ld_value)
   );

   always_comb begin
      state_d  = state_q;
      ld_rd_d  = ld_rd_q;
      ld_f3_d  = ld_f3_q;
      ld_off_d = ld_off_q;
      we_d     = 1'b0;
      rd_d     = '0;
      wval_d   = '0;
      unique case (state_q)
         StIdle: begin
            if (valid_l2) begin
               // Loads to x0 still wait so the response is consumed before l2 moves on
               if (wb_sel_l2 == WbMem) begin
                  state_d  = StWait;
                  ld_rd_d  = rd_l2;
                  ld_f3_d  = funct3_l2;
                  ld_off_d = alu_res_l2[1:0];
               end else if (rd_l2 != 5'd0) begin
                  we_d   = 1'b1;
                  rd_d   = rd_l2;
                  wval_d = (wb_sel_l2 == WbPc4) ? pc4_l2 : alu_res_l2;
               end
            end
         end
         StWait: begin
            if (dmem_rvalid) begin
               state_d = StIdle;
               if (ld_rd_q != 5'd0) begin
                  we_d   = 1'b1;
                  rd_d   = ld_rd_q;
                  wval_d = ld_value;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         ld_rd_q  <= '0;
         ld_f3_q  <= '0;
         ld_off_q <= '0;
         we_q     <= 1'b0;
         rd_q     <= '0;
         wval_q   <= '0;
      end else begin
         state_q  <= state_d;
         ld_rd_q  <= ld_rd_d;
         ld_f3_q  <= ld_f3_d;
         ld_off_q <= ld_off_d;
         we_q     <= we_d;
         rd_q     <= rd_d;
         wval_q   <= wval_d;
      end
   end

   assign stall_l2 = (state_q == StWait);
   assign we_l3    = we_q;
   assign rd_l3    = rd_q;
   assign wval_l3  = wval_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed cases plus a randomized instruction stream.
module tb_wb_stage;
   import riscv_pkg::*;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] val;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_l2;
   logic [4:0]  rd_l2;
   logic [1:0]  wb_sel_l2;
   logic [2:0]  funct3_l2;
   logic [31:0] alu_res_l2;
   logic [31:0] pc4_l2;
   logic [31:0] dmem_rdata;
   logic        dmem_rvalid;
   logic        stall_l2;
   logic        we_l3;
   logic [4:0]  rd_l3;
   logic [31:0] wval_l3;

   int  tests = 0;
   int  fails = 0;
   bit  allow_stray = 1'b0;
   wb_t exp_q[$];
   logic [31:0] pend_data;

   wb_stage #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_l2    (valid_l2),
      .rd_l2       (rd_l2),
      .wb_sel_l2   (wb_sel_l2),
      .funct3_l2   (funct3_l2),
      .alu_res_l2  (alu_res_l2),
      .pc4_l2      (pc4_l2),
      .dmem_rdata  (dmem_rdata),
      .dmem_rvalid (dmem_rvalid),
      .stall_l2    (stall_l2),
      .we_l3       (we_l3),
      .rd_l3       (rd_l3),
      .wval_l3     (wval_l3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference load result: shift the addressed lane down, mask, then extend.
   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] f3);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * off[1])) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   // Monitor: every write must match the next expected retirement; idle cycles show zeros.
   always @(negedge clk) begin
      if (rst_n) begin
         if (we_l3) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {27'd0, rd_l3}, 32'd0);
            end else begin
               wb_t e;
               e = exp_q.pop_front();
               chk("sb_rd", {27'd0, rd_l3}, {27'd0, e.rd});
               chk("sb_wval", wval_l3, e.val);
            end
         end else begin
            chk("bubble_rd", {27'd0, rd_l3}, 32'd0);
            chk("bubble_wval", wval_l3, 32'd0);
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && !allow_stray) begin
         assert (!(dmem_rvalid && !stall_l2))
         else begin
            fails++;
            $display("FAIL stray_rvalid: rvalid %b while stall %b at %0t", dmem_rvalid,
                     stall_l2, $time);
         end
      end
   end

   task automatic drive_bubble();
      valid_l2    = 1'b0;
      rd_l2       = 5'd0;
      wb_sel_l2   = 2'd0;
      funct3_l2   = 3'd0;
      alu_res_l2  = 32'd0;
      pc4_l2      = 32'd0;
      dmem_rvalid = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] pc4);
      valid_l2   = 1'b1;
      rd_l2      = rd;
      wb_sel_l2  = sel;
      funct3_l2  = f3;
      alu_res_l2 = alu;
      pc4_l2     = pc4;
   endtask

   task automatic do_simple(input string name, input logic [4:0] rd, input logic [1:0] sel,
                            input logic [31:0] alu, input logic [31:0] pc4);
      logic [31:0] ev;
      ev = (rd == 5'd0) ? 32'd0 : ((sel == 2'd2) ? pc4 : alu);
      @(posedge clk); #1;
      issue(rd, sel, 3'd0, alu, pc4);
      if (rd != 5'd0) exp_q.push_back('{rd: rd, val: ev});
      @(posedge clk); #1;
      drive_bubble();
      @(negedge clk);
      chk({name, "_we"}, {31'd0, we_l3}, {31'd0, rd != 5'd0});
      chk({name, "_rd"}, {27'd0, rd_l3}, {27'd0, rd});
      chk({name, "_wval"}, wval_l3, ev);
      chk({name, "_stall"}, {31'd0, stall_l2}, 32'd0);
   endtask

   // Load captured at edge N; rvalid driven in cycle N+k; result checked in N+k+1.
   task automatic do_load(input string name, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data, input int k,
                          input logic [31:0] ev);
      @(posedge clk); #1;
      issue(rd, 2'd1, f3, addr, 32'd0);
      if (rd != 5'd0) exp_q.push_back('{rd: rd, val: ev});
      @(posedge clk); #1;
      drive_bubble();
      for (int i = 1; i <= k; i++) begin
         if (i == k) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = data;
         end
         @(negedge clk);
         chk({name, "_stall_hi"}, {31'd0, stall_l2}, 32'd1);
         @(posedge clk); #1;
         dmem_rvalid = 1'b0;
      end
      @(negedge clk);
      chk({name, "_stall_lo"}, {31'd0, stall_l2}, 32'd0);
      chk({name, "_we"}, {31'd0, we_l3}, {31'd0, rd != 5'd0});
      chk({name, "_rd"}, {27'd0, rd_l3}, {27'd0, rd});
      chk({name, "_wval"}, wval_l3, (rd != 5'd0) ? ev : 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      dmem_rdata = 32'd0;
      pend_data  = 32'd0;
      drive_bubble();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_stall", {31'd0, stall_l2}, 32'd0);
      chk("reset_we", {31'd0, we_l3}, 32'd0);
      chk("reset_rd", {27'd0, rd_l3}, 32'd0);
      chk("reset_wval", wval_l3, 32'd0);

      do_simple("alu", 5'd5, 2'd0, 32'h0000_1234, 32'h0000_0100);
      do_simple("pc4", 5'd12, 2'd2, 32'h0000_0AAA, 32'h8000_0004);
      do_simple("rsvd_sel", 5'd3, 2'd3, 32'hCAFE_F00D, 32'h0000_0008);
      do_simple("x0_alu", 5'd0, 2'd0, 32'h0000_0055, 32'h0000_0000);
      do_load("lb", 5'd7, 3'd0, 32'h0000_1003, 32'h80FF_0000, 3, 32'hFFFF_FF80);
      do_load("lhu", 5'd9, 3'd5, 32'h0000_2002, 32'hBEEF_1234, 1, 32'h0000_BEEF);
      do_load("lh", 5'd10, 3'd1, 32'h0000_2003, 32'h8001_7FFF, 2, 32'hFFFF_8001);
      do_load("lbu", 5'd11, 3'd4, 32'h0000_2001, 32'h1234_9A78, 1, 32'h0000_009A);
      do_load("lw", 5'd13, 3'd2, 32'h0000_2000, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF);
      do_load("lrsvd", 5'd14, 3'd7, 32'h0000_2002, 32'h0BAD_CAFE, 1, 32'h0BAD_CAFE);
      do_load("ld_x0", 5'd0, 3'd2, 32'h0000_3000, 32'h1111_2222, 2, 32'd0);

      // Reset while a load is outstanding; the late response must be dropped.
      @(posedge clk); #1;
      issue(5'd9, 2'd1, 3'd2, 32'h0000_4000, 32'd0);
      @(posedge clk); #1;
      drive_bubble();
      @(negedge clk);
      chk("rst_wait_stall", {31'd0, stall_l2}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_stall", {31'd0, stall_l2}, 32'd0);
      chk("rst_mid_we", {31'd0, we_l3}, 32'd0);
      @(posedge clk); #1;
      allow_stray = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h5A5A_5A5A;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      @(negedge clk);
      chk("late_we", {31'd0, we_l3}, 32'd0);
      chk("late_rd", {27'd0, rd_l3}, 32'd0);
      chk("late_wval", wval_l3, 32'd0);
      chk("late_stall", {31'd0, stall_l2}, 32'd0);
      allow_stray = 1'b0;

      // Random stream; l2 inputs are scrambled while stalled to prove they are not captured.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (stall_l2) begin
            valid_l2   = 1'($urandom_range(0, 1));
            rd_l2      = 5'($urandom_range(0, 31));
            wb_sel_l2  = 2'($urandom_range(0, 3));
            funct3_l2  = 3'($urandom_range(0, 7));
            alu_res_l2 = $urandom;
            pc4_l2     = $urandom;
            if ($urandom_range(0, 2) == 0) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = pend_data;
            end else begin
               dmem_rvalid = 1'b0;
               dmem_rdata  = $urandom;
            end
         end else begin
            logic       v;
            logic [4:0] rd;
            logic [1:0] sel;
            logic [2:0] f3;
            logic [31:0] alu, pc4;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            v   = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            sel = 2'($urandom_range(0, 3));
            f3  = 3'($urandom_range(0, 7));
            alu = $urandom;
            pc4 = $urandom;
            issue(rd, sel, f3, alu, pc4);
            valid_l2 = v;
            if (v && rd != 5'd0) begin
               if (sel == 2'd1) begin
                  pend_data = $urandom;
                  exp_q.push_back('{rd: rd, val: ref_load(pend_data, alu[1:0], f3)});
               end else begin
                  exp_q.push_back('{rd: rd, val: (sel == 2'd2) ? pc4 : alu});
               end
            end else if (v && sel == 2'd1) begin
               pend_data = $urandom;
            end
         end
      end

      @(posedge clk); #1;
      drive_bubble();
      for (int g = 0; g < 20 && stall_l2; g++) begin
         dmem_rvalid = 1'b1;
         dmem_rdata  = pend_data;
         @(posedge clk); #1;
         dmem_rvalid = 1'b0;
      end
      chk("drain_stall", {31'd0, stall_l2}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sb_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
